// File: rtl/ex_mem_ccr_stage.sv
// ex_mem_ccr_stage
// EX/MEM pipeline boundary. It registers the ALU result, store data,
// destination index and memory/writeback controls. It also owns the
// condition-code register (CCR) and a one-deep shadow copy of the CCR,
// which is used to save and restore the flags on interrupt entry/return.
//
// Ports:
//   clk, rst                   rising-edge clock, asynchronous active-low reset
//   in_valid, stall, flush     pipeline handshake from the execute stage
//   alu_out/carry/zero/neg/op  ALU result, flags and operation code
//   store_data, rd_addr        memory write data and destination register
//   mem_read/mem_write/reg_write  control bits
//   setc, clrc                 force the carry flag set or clear
//   ccr_save, ccr_restore      copy CCR to shadow / copy shadow to CCR
//   out_*                      registered pipeline outputs
//   ccr                        {C,N,Z}
//   fwd_valid/fwd_rd/fwd_data  forwarding port back to execute (from flops only)
module ex_mem_ccr_stage #(
  parameter int N    = 16,
  parameter int RD_W = 3
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  input  logic            stall,
  input  logic            flush,
  input  logic [N-1:0]    alu_out,
  input  logic            alu_carry,
  input  logic            alu_zero,
  input  logic            alu_neg,
  input  logic [2:0]      alu_op,
  input  logic [N-1:0]    store_data,
  input  logic [RD_W-1:0] rd_addr,
  input  logic            mem_read,
  input  logic            mem_write,
  input  logic            reg_write,
  input  logic            setc,
  input  logic            clrc,
  input  logic            ccr_save,
  input  logic            ccr_restore,
  output logic            out_valid,
  output logic [N-1:0]    out_result,
  output logic [N-1:0]    out_store_data,
  output logic [RD_W-1:0] out_rd,
  output logic            out_mem_read,
  output logic            out_mem_write,
  output logic            out_reg_write,
  output logic [2:0]      ccr,
  output logic            fwd_valid,
  output logic [RD_W-1:0] fwd_rd,
  output logic [N-1:0]    fwd_data
);

  localparam logic [2:0] OP_ADD      = 3'd0;
  localparam logic [2:0] OP_NOT      = 3'd1;
  localparam logic [2:0] OP_PASS_DST = 3'd2;

  logic            valid_q,      valid_d;
  logic [N-1:0]    result_q,     result_d;
  logic [N-1:0]    store_q,      store_d;
  logic [RD_W-1:0] rd_q,         rd_d;
  logic            mem_read_q,   mem_read_d;
  logic            mem_write_q,  mem_write_d;
  logic            reg_write_q,  reg_write_d;
  logic [2:0]      ccr_q,        ccr_d;
  logic [2:0]      shadow_q,     shadow_d;

  logic            adv_s;
  logic            acc_s;
  logic [2:0]      alu_ccr_s;
  logic [2:0]      flag_ccr_s;

  // Non-stalled, non-flushed edge; acc_s additionally requires a valid instruction.
  assign adv_s = ~stall & ~flush;
  assign acc_s = in_valid & adv_s;

  // Pipeline register next-state: flush beats stall, invalid input loads a bubble.
  always_comb begin
    valid_d     = valid_q;
    result_d    = result_q;
    store_d     = store_q;
    rd_d        = rd_q;
    mem_read_d  = mem_read_q;
    mem_write_d = mem_write_q;
    reg_write_d = reg_write_q;
    if (flush) begin
      // Bubble: kill valid and side-effect controls, data fields keep old values.
      valid_d     = 1'b0;
      mem_read_d  = 1'b0;
      mem_write_d = 1'b0;
      reg_write_d = 1'b0;
    end else if (stall) begin
      valid_d     = valid_q;
      reg_write_d = reg_write_q;
    end else if (in_valid) begin
      valid_d     = 1'b1;
      result_d    = alu_out;
      store_d     = store_data;
      rd_d        = rd_addr;
      mem_read_d  = mem_read;
      mem_write_d = mem_write;
      reg_write_d = reg_write;
    end else begin
      valid_d     = 1'b0;
      mem_read_d  = 1'b0;
      mem_write_d = 1'b0;
      reg_write_d = 1'b0;
    end
  end

  // Flag update from the ALU, selected by operation code, only for accepted instructions.
  always_comb begin
    alu_ccr_s = ccr_q;
    if (acc_s) begin
      case (alu_op)
        OP_ADD:      alu_ccr_s = {alu_carry, alu_neg, alu_zero};
        OP_NOT,
        OP_PASS_DST: alu_ccr_s = {ccr_q[2], alu_neg, alu_zero};
        default:     alu_ccr_s = ccr_q;
      endcase
    end else begin
      alu_ccr_s = ccr_q;
    end
  end

  // SETC/CLRC override the carry bit only; clrc wins when both are asserted.
  always_comb begin
    flag_ccr_s = alu_ccr_s;
    if (clrc) begin
      flag_ccr_s[2] = 1'b0;
    end else if (setc) begin
      flag_ccr_s[2] = 1'b1;
    end else begin
      flag_ccr_s[2] = alu_ccr_s[2];
    end
  end

  // CCR and shadow next-state; restore overrides all flag updates, and
  // save captures the pre-edge CCR, so save+restore swaps the two.
  always_comb begin
    ccr_d    = ccr_q;
    shadow_d = shadow_q;
    if (adv_s) begin
      if (ccr_restore) begin
        ccr_d = shadow_q;
      end else begin
        ccr_d = flag_ccr_s;
      end
      if (ccr_save) begin
        shadow_d = ccr_q;
      end else begin
        shadow_d = shadow_q;
      end
    end else begin
      ccr_d    = ccr_q;
      shadow_d = shadow_q;
    end
  end

  // State registers with asynchronous active-low clear.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q     <= 1'b0;
      result_q    <= {N{1'b0}};
      store_q     <= {N{1'b0}};
      rd_q        <= {RD_W{1'b0}};
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
      reg_write_q <= 1'b0;
      ccr_q       <= 3'b000;
      shadow_q    <= 3'b000;
    end else begin
      valid_q     <= valid_d;
      result_q    <= result_d;
      store_q     <= store_d;
      rd_q        <= rd_d;
      mem_read_q  <= mem_read_d;
      mem_write_q <= mem_write_d;
      reg_write_q <= reg_write_d;
      ccr_q       <= ccr_d;
      shadow_q    <= shadow_d;
    end
  end

  assign out_valid      = valid_q;
  assign out_result     = result_q;
  assign out_store_data = store_q;
  assign out_rd         = rd_q;
  assign out_mem_read   = mem_read_q;
  assign out_mem_write  = mem_write_q;
  assign out_reg_write  = reg_write_q;
  assign ccr            = ccr_q;

  // Forwarding is taken from flops only, so no input reaches an output combinationally.
  assign fwd_valid = valid_q & reg_write_q;
  assign fwd_rd    = rd_q;
  assign fwd_data  = result_q;

endmodule

// File: tb/tb_ex_mem_ccr_stage.sv
// Directed bench for ex_mem_ccr_stage. Inputs are driven 1 ns after a rising
// edge, and outputs are checked 1 ns after the next rising edge.
module tb_ex_mem_ccr_stage;

  localparam int N    = 16;
  localparam int RD_W = 3;

  logic            clk;
  logic            rst;
  logic            in_valid, stall, flush;
  logic [N-1:0]    alu_out;
  logic            alu_carry, alu_zero, alu_neg;
  logic [2:0]      alu_op;
  logic [N-1:0]    store_data;
  logic [RD_W-1:0] rd_addr;
  logic            mem_read, mem_write, reg_write;
  logic            setc, clrc, ccr_save, ccr_restore;
  logic            out_valid;
  logic [N-1:0]    out_result, out_store_data;
  logic [RD_W-1:0] out_rd;
  logic            out_mem_read, out_mem_write, out_reg_write;
  logic [2:0]      ccr;
  logic            fwd_valid;
  logic [RD_W-1:0] fwd_rd;
  logic [N-1:0]    fwd_data;

  int n_checks;
  int n_pass;

  ex_mem_ccr_stage #(.N(N), .RD_W(RD_W)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .stall(stall), .flush(flush),
    .alu_out(alu_out), .alu_carry(alu_carry), .alu_zero(alu_zero),
    .alu_neg(alu_neg), .alu_op(alu_op),
    .store_data(store_data), .rd_addr(rd_addr),
    .mem_read(mem_read), .mem_write(mem_write), .reg_write(reg_write),
    .setc(setc), .clrc(clrc), .ccr_save(ccr_save), .ccr_restore(ccr_restore),
    .out_valid(out_valid), .out_result(out_result),
    .out_store_data(out_store_data), .out_rd(out_rd),
    .out_mem_read(out_mem_read), .out_mem_write(out_mem_write),
    .out_reg_write(out_reg_write), .ccr(ccr),
    .fwd_valid(fwd_valid), .fwd_rd(fwd_rd), .fwd_data(fwd_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic idle();
    in_valid = 1'b0; stall = 1'b0; flush = 1'b0;
    alu_out = 16'h0000; alu_carry = 1'b0; alu_zero = 1'b0; alu_neg = 1'b0;
    alu_op = 3'd0; store_data = 16'h0000; rd_addr = 3'd0;
    mem_read = 1'b0; mem_write = 1'b0; reg_write = 1'b0;
    setc = 1'b0; clrc = 1'b0; ccr_save = 1'b0; ccr_restore = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one valid ALU instruction with the given flags.
  task automatic instr(input logic [2:0] op, input logic [15:0] res,
                       input logic c, input logic z, input logic n);
    idle();
    in_valid = 1'b1; alu_op = op; alu_out = res;
    alu_carry = c; alu_zero = z; alu_neg = n;
    reg_write = 1'b1; rd_addr = 3'd5; store_data = 16'hA5A5;
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    rst = 1'b0;
    idle();

    // Reset held with inputs toggling: everything stays at zero.
    for (int i = 0; i < 4; i++) begin
      in_valid   = 1'($urandom_range(1, 0));
      alu_out    = 16'($urandom);
      alu_carry  = 1'($urandom_range(1, 0));
      alu_op     = 3'($urandom_range(7, 0));
      reg_write  = 1'b1;
      setc       = 1'b1;
      ccr_save   = 1'($urandom_range(1, 0));
      tick();
    end
    chk("rst_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_result", {16'd0, out_result}, 32'd0);
    chk("rst_ccr", {29'd0, ccr}, 32'd0);
    idle();
    rst = 1'b1;
    tick();
    chk("post_rst_valid", {31'd0, out_valid}, 32'd0);
    chk("post_rst_ccr", {29'd0, ccr}, 32'd0);
    chk("post_rst_fwd", {31'd0, fwd_valid}, 32'd0);

    // ADD loads all three flags.
    instr(3'd0, 16'h0000, 1'b1, 1'b1, 1'b0);
    mem_write = 1'b1; store_data = 16'h1234;
    tick();
    chk("add_result", {16'd0, out_result}, 32'h0000);
    chk("add_ccr", {29'd0, ccr}, 32'h5);
    chk("add_valid", {31'd0, out_valid}, 32'd1);
    chk("add_store", {16'd0, out_store_data}, 32'h1234);
    chk("add_memw", {31'd0, out_mem_write}, 32'd1);
    chk("add_fwd_valid", {31'd0, fwd_valid}, 32'd1);
    chk("add_fwd_rd", {29'd0, fwd_rd}, 32'd5);

    // Pass-src leaves flags alone.
    instr(3'd3, 16'h8000, 1'b0, 1'b0, 1'b1);
    tick();
    chk("pass_src_result", {16'd0, fwd_data}, 32'h8000);
    chk("pass_src_ccr", {29'd0, ccr}, 32'h5);

    // ADD to reach 100, then NOT keeps C and loads N,Z -> 110.
    instr(3'd0, 16'h0001, 1'b1, 1'b0, 1'b0);
    tick();
    chk("pre_not_ccr", {29'd0, ccr}, 32'h4);
    instr(3'd1, 16'hFFFF, 1'b0, 1'b0, 1'b1);
    tick();
    chk("not_ccr", {29'd0, ccr}, 32'h6);
    chk("not_result", {16'd0, out_result}, 32'hFFFF);

    // Opcodes 4-7 never touch the flags.
    instr(3'd6, 16'h0F0F, 1'b0, 1'b1, 1'b0);
    tick();
    chk("op6_ccr", {29'd0, ccr}, 32'h6);

    // Stall for three cycles with changing inputs, flag controls included.
    for (int i = 0; i < 3; i++) begin
      instr(3'd0, 16'h1111 * 16'(i + 1), 1'b0, 1'b1, 1'b0);
      stall = 1'b1; setc = (i == 0); clrc = (i == 1); ccr_restore = (i == 2);
      tick();
      chk("stall_result", {16'd0, out_result}, 32'h0F0F);
      chk("stall_ccr", {29'd0, ccr}, 32'h6);
    end

    // Stall and flush together: bubble, data held, flags frozen.
    instr(3'd0, 16'h2222, 1'b0, 1'b1, 1'b0);
    stall = 1'b1; flush = 1'b1; clrc = 1'b1;
    tick();
    chk("flush_valid", {31'd0, out_valid}, 32'd0);
    chk("flush_regw", {31'd0, out_reg_write}, 32'd0);
    chk("flush_result_hold", {16'd0, out_result}, 32'h0F0F);
    chk("flush_ccr", {29'd0, ccr}, 32'h6);

    // Release: pass-dst loads N,Z, and C holds at 1.
    instr(3'd2, 16'h1234, 1'b0, 1'b0, 1'b0);
    tick();
    chk("release_valid", {31'd0, out_valid}, 32'd1);
    chk("release_result", {16'd0, out_result}, 32'h1234);
    chk("pass_dst_ccr", {29'd0, ccr}, 32'h4);

    // Invalid input loads a bubble and holds the data.
    idle();
    tick();
    chk("bubble_valid", {31'd0, out_valid}, 32'd0);
    chk("bubble_result", {16'd0, out_result}, 32'h1234);

    // SETC overrides the ALU carry, and N,Z still come from the ALU.
    instr(3'd0, 16'h8000, 1'b0, 1'b0, 1'b1);
    setc = 1'b1;
    tick();
    chk("setc_add_ccr", {29'd0, ccr}, 32'h6);

    // When both setc and clrc are high, clear wins.
    instr(3'd0, 16'h0000, 1'b1, 1'b1, 1'b0);
    setc = 1'b1; clrc = 1'b1;
    tick();
    chk("setc_clrc_ccr", {29'd0, ccr}, 32'h1);

    // SETC with no valid instruction.
    idle();
    setc = 1'b1;
    tick();
    chk("setc_idle_ccr", {29'd0, ccr}, 32'h5);
    chk("setc_idle_valid", {31'd0, out_valid}, 32'd0);

    // Reach 011, save it, then let an ADD change the flags and restore them.
    instr(3'd0, 16'h8000, 1'b0, 1'b1, 1'b1);
    tick();
    chk("pre_save_ccr", {29'd0, ccr}, 32'h3);
    idle();
    ccr_save = 1'b1;
    tick();
    chk("save_ccr", {29'd0, ccr}, 32'h3);
    instr(3'd0, 16'h0001, 1'b1, 1'b0, 1'b0);
    tick();
    chk("mid_add_ccr", {29'd0, ccr}, 32'h4);
    instr(3'd0, 16'h0002, 1'b0, 1'b1, 1'b1);
    setc = 1'b1; ccr_restore = 1'b1;
    tick();
    chk("restore_ccr", {29'd0, ccr}, 32'h3);

    // Swap: ccr 100 and shadow 011 become 011 and 100.
    instr(3'd0, 16'h0003, 1'b1, 1'b0, 1'b0);
    tick();
    chk("pre_swap_ccr", {29'd0, ccr}, 32'h4);
    idle();
    ccr_save = 1'b1; ccr_restore = 1'b1;
    tick();
    chk("swap_ccr", {29'd0, ccr}, 32'h3);
    idle();
    ccr_restore = 1'b1;
    tick();
    chk("swap_shadow", {29'd0, ccr}, 32'h4);

    // Asynchronous reset mid-stream clears state before the next edge.
    instr(3'd0, 16'h7777, 1'b1, 1'b0, 1'b0);
    tick();
    chk("pre_async_valid", {31'd0, out_valid}, 32'd1);
    idle();
    #2;
    rst = 1'b0;
    #1;
    chk("async_valid", {31'd0, out_valid}, 32'd0);
    chk("async_result", {16'd0, out_result}, 32'd0);
    chk("async_ccr", {29'd0, ccr}, 32'd0);
    chk("async_fwd", {31'd0, fwd_valid}, 32'd0);
    tick();
    rst = 1'b1;
    ccr_restore = 1'b1;
    tick();
    chk("async_shadow", {29'd0, ccr}, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/ex_mem_ccr_stage.md
Name: ex_mem_ccr_stage

Overview:
- Pipeline stage directly downstream of the execute-stage ALU: registers ALU result, store data and writeback control into the EX/MEM boundary.
- Owns the condition-code register (CCR) and updates it from the ALU's carry/zero/negative outputs according to the ALU operation code.
- Supports stall, flush, SETC/CLRC, and a one-deep CCR save/restore used on interrupt entry/return.
- Drives a forwarding port back to the execute stage.

Parameters:
N, 16, datapath width (matches ALU width)
RD_W, 3, destination register index width

Ports:
clk  in  1  rising-edge clock
rst  in  1  asynchronous, active-low reset
in_valid  in  1  execute stage presents a valid instruction
stall  in  1  hold every register this cycle
flush  in  1  kill the incoming instruction (bubble inserted)
alu_out  in  N  ALU result
alu_carry  in  1  ALU carry output
alu_zero  in  1  ALU zero output
alu_neg  in  1  ALU negative output
alu_op  in  3  ALU control signal for this instruction
store_data  in  N  data for memory write
rd_addr  in  RD_W  destination register
mem_read, mem_write, reg_write  in  1 each  control bits
setc, clrc  in  1 each  force carry set/clear
ccr_save, ccr_restore  in  1 each  save CCR to shadow / restore CCR from shadow
out_valid  out  1  registered valid
out_result  out  N  registered ALU result
out_store_data  out  N  registered store data
out_rd  out  RD_W  registered destination
out_mem_read, out_mem_write, out_reg_write  out  1 each  registered controls
ccr  out  3  {C,N,Z}: bit2=C, bit1=N, bit0=Z
fwd_valid  out  1  out_valid & out_reg_write
fwd_rd  out  RD_W  equals out_rd
fwd_data  out  N  equals out_result

Behaviour:
- Reset (rst=0, async): every output 0, shadow CCR 0. The first rising clk edge after rst deasserts behaves normally.
- Accept condition: acc = in_valid & ~stall & ~flush.
- Priority per edge: flush > stall > normal. Flush overrides stall.
- Pipeline register, latency 1:
  - On acc, all out_* take the inputs and out_valid=1.
  - On flush, out_valid=0, out_mem_read/out_mem_write/out_reg_write=0, and data fields hold their previous values.
  - On stall without flush, all registers hold.
  - With ~in_valid & ~stall & ~flush, a bubble is loaded exactly as for flush.
- CCR ALU update, applied only on acc:
  - alu_op 0 (add): C,N,Z all load from the ALU.
  - alu_op 1 (not) and alu_op 2 (pass dst): N,Z load; C holds.
  - alu_op 3 (pass src) and alu_op 4-7: no flag change.
- SETC/CLRC:
  - Act whenever ~stall & ~flush, independent of in_valid.
  - They override the C bit from an ALU update in the same cycle; N,Z still update from the ALU.
  - If setc and clrc are both high, clrc wins (C=0).
- ccr_restore:
  - Acts when ~stall & ~flush.
  - CCR <= shadow, overriding every ALU update and setc/clrc that cycle.
- ccr_save:
  - Acts when ~stall & ~flush.
  - shadow <= current CCR, i.e. the value before this edge's update.
  - Save and restore in the same cycle swap: CCR gets the old shadow, shadow gets the old CCR.
- Flush and stall freeze CCR and shadow completely.
- The forwarding outputs are combinational from registered state only. There is no combinational path from any input to any output.
- No wrap or overflow logic in this stage: widths pass through unchanged.

Test Plan:
- Reset: hold rst=0 with random inputs toggling, then release -> all outputs 0, ccr=3'b000. Assert rst mid-stream with out_valid=1 -> outputs clear immediately, without waiting for a clk edge.
- ADD flags: alu_op=0, alu_out=16'h0000, carry=1, zero=1, neg=0, in_valid=1 -> next cycle out_result=0, ccr=3'b101. Then alu_op=3, alu_out=16'h8000, neg=1 -> ccr stays 3'b101, out_result=16'h8000.
- NOT keeps carry: start with ccr=3'b100, apply alu_op=1, alu_out=16'hFFFF, neg=1, carry=0 -> ccr=3'b110.
- Stall/flush:
  - Stall=1 for 3 cycles with changing inputs -> outputs and ccr frozen.
  - Stall=1 and flush=1 together -> out_valid=0, out_reg_write=0, ccr unchanged.
  - Release both -> the next valid instruction appears after 1 cycle.
- SETC/CLRC priority:
  - ADD with carry=0 plus setc=1 -> C=1, N/Z from the ALU.
  - setc=clrc=1 -> C=0.
  - setc with in_valid=0 -> C=1 and out_valid=0.
- Save/restore:
  - With ccr=3'b011, pulse ccr_save; run an ADD that sets ccr=3'b100; pulse ccr_restore -> ccr=3'b011.
  - Save+restore together with ccr=3'b100, shadow=3'b011 -> ccr=3'b011, shadow=3'b100, confirmed by a following restore.
